// File: rtl/orion_clk_en_gen.sv
// Lock synchroniser, post-lock reset sequencer and NUM_CH reloadable clock-enable dividers.
// Define ORION_CLKEN_PHASE_EN to add a 50% duty divided-phase flop per channel on ph_out.
module orion_clk_en_gen #(
    parameter int unsigned             NUM_CH    = 2,
    parameter int unsigned             DIV_W     = 8,
    parameter int unsigned             LOCK_SYNC = 2,
    parameter int unsigned             RST_HOLD  = 16,
    parameter logic [NUM_CH*DIV_W-1:0] DIV_INIT  = {NUM_CH{8'd1}}
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pll_locked,
    input  logic [NUM_CH*DIV_W-1:0] div_cfg,
    input  logic                    div_load,
    input  logic                    lock_lost_clr,
    output logic                    sys_rst_n,
    output logic                    ready,
    output logic                    lock_lost,
    output logic [NUM_CH-1:0]       ce_out,
    output logic [NUM_CH-1:0]       ph_out
);

    typedef enum logic [1:0] {
        WAIT_LOCK,
        HOLD,
        RUN
    } state_t;

    localparam logic [15:0] HOLD_LAST = 16'(RST_HOLD - 1);

    state_t               state;
    logic [LOCK_SYNC-1:0] lock_sync;
    logic                 lock_s;
    logic [15:0]          hold_cnt;
    logic                 run_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_sync <= '0;
        end else begin
            lock_sync <= {lock_sync[LOCK_SYNC-2:0], pll_locked};
        end
    end

    assign lock_s    = lock_sync[LOCK_SYNC-1];
    assign run_state = (state == RUN);

    // sys_rst_n/ready are loaded with the next-state decode so they rise on the first RUN cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= WAIT_LOCK;
            hold_cnt  <= '0;
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    hold_cnt <= '0;
                    if (lock_s) begin
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (!lock_s) begin
                        state    <= WAIT_LOCK;
                        hold_cnt <= '0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state     <= RUN;
                        sys_rst_n <= 1'b1;
                        ready     <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 16'd1;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state     <= WAIT_LOCK;
                        hold_cnt  <= '0;
                        sys_rst_n <= 1'b0;
                        ready     <= 1'b0;
                    end
                end
                default: begin
                    state     <= WAIT_LOCK;
                    hold_cnt  <= '0;
                    sys_rst_n <= 1'b0;
                    ready     <= 1'b0;
                end
            endcase
        end
    end

    // A loss in the same cycle as a clear keeps the flag set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_lost <= 1'b0;
        end else if (run_state && !lock_s) begin
            lock_lost <= 1'b1;
        end else if (lock_lost_clr) begin
            lock_lost <= 1'b0;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DIV_W-1:0] cnt;
        logic [DIV_W-1:0] div_act;
        logic [DIV_W-1:0] div_shd;
        logic             pend;
        logic             wrap;

        assign ce_out[i] = run_state && (cnt == div_act);
        // Outside RUN every cycle acts as a wrap point, so pending values apply immediately
        assign wrap      = !run_state || ce_out[i];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt     <= '0;
                div_act <= DIV_INIT[i*DIV_W +: DIV_W];
                div_shd <= DIV_INIT[i*DIV_W +: DIV_W];
                pend    <= 1'b0;
            end else begin
                if (wrap) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                if (pend && wrap) begin
                    div_act <= div_shd;
                end
                if (div_load) begin
                    div_shd <= div_cfg[i*DIV_W +: DIV_W];
                    pend    <= 1'b1;
                end else if (wrap) begin
                    pend <= 1'b0;
                end
            end
        end
    end

`ifdef ORION_CLKEN_PHASE_EN
    logic run_hold;

    assign run_hold = run_state && lock_s;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ph
        logic ph;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ph <= 1'b0;
            end else if (!run_hold) begin
                ph <= 1'b0;
            end else if (ce_out[i]) begin
                ph <= ~ph;
            end
        end

        assign ph_out[i] = ph;
    end
`else
    assign ph_out = '0;
`endif

endmodule

// File: tb/tb_orion_clk_en_gen.sv
// Self-checking bench for orion_clk_en_gen: per-cycle scoreboard against a schedule-based
// reference model, plus directed lock-latency, lock-loss, reload and async-reset checks.
module tb_orion_clk_en_gen;

    localparam int NUM_CH    = 2;
    localparam int DIV_W     = 8;
    localparam int LOCK_SYNC = 2;
    localparam int RST_HOLD  = 16;
    localparam int LOCK_LAT  = LOCK_SYNC + RST_HOLD + 1;
`ifdef ORION_CLKEN_PHASE_EN
    localparam bit PH_EN = 1'b1;
`else
    localparam bit PH_EN = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b1;
    logic                    pll_locked;
    logic [NUM_CH*DIV_W-1:0] div_cfg;
    logic                    div_load;
    logic                    lock_lost_clr;
    logic                    sys_rst_n;
    logic                    ready;
    logic                    lock_lost;
    logic [NUM_CH-1:0]       ce_out;
    logic [NUM_CH-1:0]       ph_out;

    orion_clk_en_gen #(
        .NUM_CH   (NUM_CH),
        .DIV_W    (DIV_W),
        .LOCK_SYNC(LOCK_SYNC),
        .RST_HOLD (RST_HOLD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pll_locked   (pll_locked),
        .div_cfg      (div_cfg),
        .div_load     (div_load),
        .lock_lost_clr(lock_lost_clr),
        .sys_rst_n    (sys_rst_n),
        .ready        (ready),
        .lock_lost    (lock_lost),
        .ce_out       (ce_out),
        .ph_out       (ph_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              srst;
        logic              rdy;
        logic              lost;
        logic [NUM_CH-1:0] ce;
        logic [NUM_CH-1:0] ph;
    } obs_t;

    localparam obs_t RST_OBS = '0;

    int   vectors     = 0;
    int   miscompares = 0;
    obs_t expq[$];

    function automatic obs_t observe();
        return {sys_rst_n, ready, lock_lost, ce_out, ph_out};
    endfunction

    task automatic check_obs(input string name, input obs_t got, input obs_t want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s @%0t: got srst/rdy/lost/ce/ph=%b/%b/%b/%b/%b required %b/%b/%b/%b/%b",
                     name, $time, got.srst, got.rdy, got.lost, got.ce, got.ph,
                     want.srst, want.rdy, want.lost, want.ce, want.ph);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s @%0t: got %b required %b", name, $time, got, want);
        end
    endtask

    task automatic check_rng(input string name, input int got, input int lo, input int hi);
        vectors++;
        if (got < lo || got > hi) begin
            miscompares++;
            $display("FAIL %s: got %0d required %0d..%0d", name, got, lo, hi);
        end
    endtask

    // Reference model: RUN holds once the synchronised lock has been high for RST_HOLD+1
    // consecutive cycles; each channel fires at a scheduled RUN-cycle index.
    bit   m_syncq[$];
    bit   m_s;
    int   m_streak;
    bit   m_run;
    int   m_rc;
    bit   m_lost;
    int   m_act   [NUM_CH];
    int   m_shd   [NUM_CH];
    bit   m_pend  [NUM_CH];
    int   m_nfire [NUM_CH];
    bit   m_ce    [NUM_CH];
    bit   m_ph    [NUM_CH];
    obs_t m_obs;

    task automatic model_reset();
        m_syncq = {};
        for (int k = 0; k < LOCK_SYNC; k++) m_syncq.push_back(1'b0);
        m_s = 0; m_streak = 0; m_run = 0; m_rc = 0; m_lost = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_act[i] = 1; m_shd[i] = 1; m_pend[i] = 0;
            m_nfire[i] = 0; m_ce[i] = 0; m_ph[i] = 0;
        end
        m_obs = RST_OBS;
    endtask

    task automatic model_step();
        bit run_n;
        if (m_run && !m_s) m_lost = 1;
        else if (lock_lost_clr) m_lost = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (m_pend[i] && (!m_run || m_ce[i])) begin
                m_act[i]  = m_shd[i];
                m_pend[i] = 0;
            end
            if (m_run && m_ce[i]) m_nfire[i] = m_rc + m_act[i] + 1;
            if (div_load) begin
                m_shd[i]  = int'(div_cfg[i*DIV_W +: DIV_W]);
                m_pend[i] = 1;
            end
        end
        m_streak = m_s ? m_streak + 1 : 0;
        run_n    = (m_streak >= RST_HOLD + 1);
        m_syncq.push_back(pll_locked);
        void'(m_syncq.pop_front());
        m_s = m_syncq[0];
        if (run_n) begin
            if (m_run) begin
                m_rc++;
            end else begin
                m_rc = 0;
                for (int i = 0; i < NUM_CH; i++) m_nfire[i] = m_act[i];
            end
        end
        m_obs = RST_OBS;
        m_obs.srst = run_n;
        m_obs.rdy  = run_n;
        m_obs.lost = m_lost;
        for (int i = 0; i < NUM_CH; i++) begin
            m_ph[i]     = run_n ? (m_ph[i] ^ m_ce[i]) : 1'b0;
            m_ce[i]     = run_n && (m_rc == m_nfire[i]);
            m_obs.ce[i] = m_ce[i];
            m_obs.ph[i] = PH_EN & m_ph[i];
        end
        m_run = run_n;
    endtask

    always @(posedge clk) begin
        if (!rst_n) model_reset();
        else model_step();
        expq.push_back(m_obs);
    end

    always @(negedge clk) begin : monitor
        obs_t want;
        if (expq.size() != 0) begin
            want = expq.pop_front();
            if (!rst_n) want = RST_OBS;
            check_obs("cycle_outputs", observe(), want);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!ready && n < 200);
    endtask

    int n;

    initial begin
        pll_locked    = 1'b0;
        div_cfg       = '0;
        div_load      = 1'b0;
        lock_lost_clr = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_obs("reset_state", observe(), RST_OBS);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        step(3);

        pll_locked = 1'b1;
        wait_ready(n);
        check_rng("lock_latency", n, LOCK_LAT - 1, LOCK_LAT + 1);
        step(12);

        // Lock loss in RUN with a clear on the detection cycle
        pll_locked = 1'b0;
        step(LOCK_SYNC);
        lock_lost_clr = 1'b1;
        step(1);
        lock_lost_clr = 1'b0;
        check_bit("lost_set_wins", lock_lost, 1'b1);
        check_bit("rst_on_loss", sys_rst_n, 1'b0);
        step(3);
        lock_lost_clr = 1'b1;
        step(1);
        lock_lost_clr = 1'b0;
        check_bit("lost_cleared", lock_lost, 1'b0);

        div_cfg  = {8'd0, 8'd4};
        div_load = 1'b1;
        step(1);
        div_load = 1'b0;
        step(2);

        // Glitch during HOLD must restart the full hold count
        pll_locked = 1'b1;
        step(12);
        pll_locked = 1'b0;
        step(3);
        pll_locked = 1'b1;
        wait_ready(n);
        check_rng("relock_full_hold", n, LOCK_LAT - 1, LOCK_LAT + 1);
        check_bit("glitch_no_lost", lock_lost, 1'b0);

        // Now at RUN cycle 0: ch0 div 4 reloaded to 2 at cycle 2, ch1 div 0
        for (int c = 0; c <= 14; c++) begin
            check_bit("reload_ce0", ce_out[0], (c == 4 || c == 7 || c == 10 || c == 13));
            check_bit("div0_ce1", ce_out[1], 1'b1);
            if (c == 2) begin
                #1;
                div_cfg  = {8'd0, 8'd2};
                div_load = 1'b1;
            end
            if (c == 3) begin
                #1;
                div_load = 1'b0;
            end
            @(posedge clk);
            #1;
        end

        for (int k = 0; k < 3000; k++) begin
            step(1);
            div_load = ($urandom_range(0, 9) == 0);
            if (div_load) begin
                for (int i = 0; i < NUM_CH; i++) div_cfg[i*DIV_W +: DIV_W] = 8'($urandom_range(0, 5));
            end
            lock_lost_clr = ($urandom_range(0, 19) == 0);
            if (pll_locked && $urandom_range(0, 299) == 0) pll_locked = 1'b0;
            else if (!pll_locked && $urandom_range(0, 3) == 0) pll_locked = 1'b1;
        end
        step(1);
        div_load      = 1'b0;
        lock_lost_clr = 1'b0;

        // Asynchronous reset in the middle of RUN
        pll_locked = 1'b1;
        wait_ready(n);
        check_bit("ready_before_reset", ready, 1'b1);
        step(5);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_obs("async_reset", observe(), RST_OBS);
        @(posedge clk);
        #2 rst_n = 1'b1;
        step(60);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
